// File: rtl/spi_fetch_prefetch_pkg.sv
// Shared constants and the read-FSM state type for the fetch/prefetch bridge.
// Response codes are the AXI4-Lite RRESP/BRESP encodings.
package spi_fetch_prefetch_pkg;

    localparam logic [31:0] SPI_FLASH_LIMIT    = 32'h0000_8000;
    localparam logic [1:0]  AXI4_RESP_L_OKAY   = 2'b00;
    localparam logic [1:0]  AXI4_RESP_L_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        HIT_RESP,
        ERR_RESP,
        MISS_AR,
        MISS_R,
        MISS_RESP,
        PF_AR,
        PF_R
    } fetch_state_t;

endpackage

// File: rtl/spi_fetch_prefetch_if.sv
// AXI4-Lite bus bundle with master/slave views.
// Write and read channels are both present; users tie off the ones they do not use.
interface axi4_lite_if #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 32
);
    logic                   awvalid;
    logic                   awready;
    logic [ADDR_SIZE-1:0]   awaddr;
    logic                   wvalid;
    logic                   wready;
    logic [DATA_SIZE-1:0]   wdata;
    logic [DATA_SIZE/8-1:0] wstrb;
    logic                   bvalid;
    logic                   bready;
    logic [1:0]             bresp;
    logic                   arvalid;
    logic                   arready;
    logic [ADDR_SIZE-1:0]   araddr;
    logic                   rvalid;
    logic                   rready;
    logic [DATA_SIZE-1:0]   rdata;
    logic [1:0]             rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/spi_fetch_prefetch.sv
// Read-only fetch bridge with a one-word next-line prefetch buffer; hit/error respond 1 cycle after AR,
// misses 1 cycle after the flash R beat. Core AR is stalled while any flash transaction is in flight.
module spi_fetch_prefetch
    import spi_fetch_prefetch_pkg::*;
#(
    parameter bit          PREFETCH_EN = 1'b1,
    parameter logic [31:0] FLASH_LIMIT = SPI_FLASH_LIMIT
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    axi4_lite_if.slave  core,
    axi4_lite_if.master flash
);

    fetch_state_t state;
    logic [31:0]  req;
    logic         pf_vld;
    logic [29:0]  pf_tag;
    logic [31:0]  pf_dat;

    logic         ar_rdy;
    logic         r_vld;
    logic [31:0]  r_dat;
    logic [1:0]   r_resp;
    logic         f_arvld;
    logic [31:0]  f_araddr;
    logic         f_rrdy;

    logic         aw_rdy;
    logic         w_rdy;
    logic         aw_cap;
    logic         w_cap;
    logic         b_vld;

    logic [31:0]  req_word;
    logic [32:0]  next_addr;
    logic         pf_ok;

    assign req_word  = {core.araddr[31:2], 2'b00};
    // 33-bit sum so an address near 2^32 cannot wrap below the limit
    assign next_addr = {1'b0, req} + 33'd4;
    assign pf_ok     = next_addr < {1'b0, FLASH_LIMIT};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state    <= IDLE;
            req      <= '0;
            pf_vld   <= 1'b0;
            pf_tag   <= '0;
            pf_dat   <= '0;
            ar_rdy   <= 1'b0;
            r_vld    <= 1'b0;
            r_dat    <= '0;
            r_resp   <= AXI4_RESP_L_SLVERR;
            f_arvld  <= 1'b0;
            f_araddr <= '0;
            f_rrdy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_rdy && core.arvalid) begin
                        ar_rdy <= 1'b0;
                        req    <= req_word;
                        if (req_word >= FLASH_LIMIT) begin
                            state  <= ERR_RESP;
                            r_vld  <= 1'b1;
                            r_dat  <= '0;
                            r_resp <= AXI4_RESP_L_SLVERR;
                        end else if (pf_vld && pf_tag == core.araddr[31:2]) begin
                            state  <= HIT_RESP;
                            r_vld  <= 1'b1;
                            r_dat  <= pf_dat;
                            r_resp <= AXI4_RESP_L_OKAY;
                        end else begin
                            state    <= MISS_AR;
                            f_arvld  <= 1'b1;
                            f_araddr <= req_word;
                        end
                    end else begin
                        ar_rdy <= 1'b1;
                    end
                end
                HIT_RESP: begin
                    if (core.rready) begin
                        r_vld  <= 1'b0;
                        pf_vld <= 1'b0;
                        ar_rdy <= 1'b1;
                        state  <= IDLE;
                    end
                end
                ERR_RESP: begin
                    if (core.rready) begin
                        r_vld  <= 1'b0;
                        ar_rdy <= 1'b1;
                        state  <= IDLE;
                    end
                end
                MISS_AR: begin
                    if (flash.arready) begin
                        f_arvld <= 1'b0;
                        f_rrdy  <= 1'b1;
                        state   <= MISS_R;
                    end
                end
                MISS_R: begin
                    if (flash.rvalid) begin
                        f_rrdy <= 1'b0;
                        r_vld  <= 1'b1;
                        r_dat  <= flash.rdata;
                        r_resp <= flash.rresp;
                        state  <= MISS_RESP;
                    end
                end
                MISS_RESP: begin
                    if (core.rready) begin
                        r_vld <= 1'b0;
                        if (r_resp != AXI4_RESP_L_OKAY) begin
                            pf_vld <= 1'b0;
                        end
                        if (PREFETCH_EN && r_resp == AXI4_RESP_L_OKAY && pf_ok) begin
                            f_arvld  <= 1'b1;
                            f_araddr <= next_addr[31:0];
                            state    <= PF_AR;
                        end else begin
                            ar_rdy <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                PF_AR: begin
                    if (flash.arready) begin
                        f_arvld <= 1'b0;
                        f_rrdy  <= 1'b1;
                        state   <= PF_R;
                    end
                end
                PF_R: begin
                    if (flash.rvalid) begin
                        f_rrdy <= 1'b0;
                        if (flash.rresp == AXI4_RESP_L_OKAY) begin
                            pf_vld <= 1'b1;
                            pf_tag <= next_addr[31:2];
                            pf_dat <= flash.rdata;
                        end else begin
                            pf_vld <= 1'b0;
                        end
                        ar_rdy <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Writes are never forwarded: collect AW and W in any order, then answer SLVERR.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_rdy <= 1'b0;
            w_rdy  <= 1'b0;
            aw_cap <= 1'b0;
            w_cap  <= 1'b0;
            b_vld  <= 1'b0;
        end else if (b_vld && core.bready) begin
            b_vld  <= 1'b0;
            aw_cap <= 1'b0;
            w_cap  <= 1'b0;
            aw_rdy <= 1'b1;
            w_rdy  <= 1'b1;
        end else begin
            if (aw_rdy && core.awvalid) begin
                aw_cap <= 1'b1;
                aw_rdy <= 1'b0;
            end else if (!aw_cap) begin
                aw_rdy <= 1'b1;
            end
            if (w_rdy && core.wvalid) begin
                w_cap <= 1'b1;
                w_rdy <= 1'b0;
            end else if (!w_cap) begin
                w_rdy <= 1'b1;
            end
            if (aw_cap && w_cap) begin
                b_vld <= 1'b1;
            end
        end
    end

    assign core.arready = ar_rdy;
    assign core.rvalid  = r_vld;
    assign core.rdata   = r_dat;
    assign core.rresp   = r_resp;
    assign core.awready = aw_rdy;
    assign core.wready  = w_rdy;
    assign core.bvalid  = b_vld;
    assign core.bresp   = AXI4_RESP_L_SLVERR;

    assign flash.arvalid = f_arvld;
    assign flash.araddr  = f_araddr;
    assign flash.rready  = f_rrdy;
    assign flash.awvalid = 1'b0;
    assign flash.awaddr  = '0;
    assign flash.wvalid  = 1'b0;
    assign flash.wdata   = '0;
    assign flash.wstrb   = '0;
    assign flash.bready  = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{core.araddr[1:0], core.awaddr, core.wdata, core.wstrb,
                         flash.awready, flash.wready, flash.bvalid, flash.bresp};

endmodule

// File: tb/tb_spi_fetch_prefetch.sv
// Scoreboard bench: a behavioural buffer model predicts core responses and flash reads;
// a flash responder and a core R monitor compare independently of the stimulus thread.
module tb_spi_fetch_prefetch;

    localparam logic [31:0] LIMIT  = 32'h0000_8000;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    axi4_lite_if core ();
    axi4_lite_if flash ();

    spi_fetch_prefetch #(.PREFETCH_EN(1'b1), .FLASH_LIMIT(LIMIT)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .core(core), .flash(flash)
    );

    typedef struct { logic [31:0] dat; logic [1:0] resp; bit miss; int hs; } rexp_t;
    typedef struct { logic [31:0] addr; bit demand; int hs; } fexp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    rexp_t exp_r[$];
    fexp_t exp_f[$];
    bit m_vld = 0;
    logic [31:0] m_addr = 0, m_dat = 0;
    int f_pushed = 0, f_done = 0, f_rhs = 0, f_delay_force = -1;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic bit is_err(input logic [31:0] a);
        return (a == 32'h40) || (((a >> 2) % 13) == 7);
    endfunction

    // Reference: one-entry buffer filled only by the next-word fetch after a good miss.
    task automatic model_read(input logic [31:0] raw);
        logic [31:0] a;
        logic [32:0] nxt;
        rexp_t r;
        fexp_t f;
        a = raw & 32'hFFFF_FFFC;
        r.hs = cyc;
        r.miss = 0;
        if (a >= LIMIT) begin
            r.dat = 0; r.resp = SLVERR;
        end else if (m_vld && m_addr == a) begin
            r.dat = m_dat; r.resp = OKAY; m_vld = 0;
        end else begin
            r.miss = 1; r.dat = mem_word(a); r.resp = is_err(a) ? SLVERR : OKAY;
            f.addr = a; f.demand = 1; f.hs = cyc;
            exp_f.push_back(f); f_pushed++;
            nxt = {1'b0, a} + 33'd4;
            if (is_err(a)) begin
                m_vld = 0;
            end else if (nxt < {1'b0, LIMIT}) begin
                f.addr = nxt[31:0]; f.demand = 0;
                exp_f.push_back(f); f_pushed++;
                m_vld = !is_err(nxt[31:0]); m_addr = nxt[31:0]; m_dat = mem_word(nxt[31:0]);
            end
        end
        exp_r.push_back(r);
    endtask

    // Called at a negedge; returns at the negedge after the AR handshake with arvalid low.
    task automatic do_read(input logic [31:0] addr);
        core.arvalid = 1'b1;
        core.araddr  = addr;
        for (int i = 0; i < 400; i++) begin
            if (core.arready) begin
                chk("ar_only_when_flash_idle", f_done, f_pushed);
                model_read(addr);
                @(negedge ACLK);
                core.arvalid = 1'b0;
                return;
            end
            @(negedge ACLK);
        end
        chk("ar_handshake_timeout", core.arready, 1);
        core.arvalid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (exp_r.size() == 0 && f_done == f_pushed) return;
            @(negedge ACLK);
        end
        chk("idle_timeout", exp_r.size(), 0);
    endtask

    // Flash responder: random AR accept and read latency, data/resp derived from the address.
    int f_st = 0, f_cnt = 0;
    bit f_seen = 0;
    logic [31:0] f_addr = 0;
    fexp_t fe;
    always @(negedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            f_st = 0; f_seen = 0;
            flash.arready = 0; flash.rvalid = 0; flash.rdata = 0; flash.rresp = 0;
        end else begin
            case (f_st)
                0: begin
                    if (flash.arready) begin
                        flash.arready = 0; f_seen = 0; f_st = 1;
                        f_cnt = (f_delay_force >= 0) ? f_delay_force : $urandom_range(1, 6);
                    end else if (flash.arvalid) begin
                        if (!f_seen) begin
                            f_seen = 1; f_addr = flash.araddr;
                            if (exp_f.size() == 0) chk("flash_ar_unexpected", flash.araddr, 32'hFFFF_FFFF);
                            else begin
                                fe = exp_f.pop_front();
                                chk("flash_araddr", flash.araddr, fe.addr);
                                if (fe.demand) chk("flash_ar_latency", cyc - fe.hs, 1);
                            end
                        end else chk("flash_ar_stable", flash.araddr, f_addr);
                        if ($urandom_range(0, 2) != 0) flash.arready = 1;
                    end
                end
                1: begin
                    if (f_cnt > 1) f_cnt--;
                    else begin
                        chk("flash_rready", flash.rready, 1);
                        flash.rvalid = 1; flash.rdata = mem_word(f_addr);
                        flash.rresp = is_err(f_addr) ? SLVERR : OKAY;
                        f_rhs = cyc; f_done++; f_st = 2;
                    end
                end
                default: begin
                    flash.rvalid = 0; flash.rdata = 0; f_st = 0;
                end
            endcase
        end
    end

    // Core R monitor: random rready backpressure, latency, stability and data checks.
    bit r_seen = 0, r_hs_pend = 0;
    logic [33:0] r_saved = 0;
    rexp_t cur;
    always @(negedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            core.rready = 0; r_seen = 0; r_hs_pend = 0;
        end else if (r_hs_pend) begin
            r_hs_pend = 0; r_seen = 0; core.rready = 0;
        end else if (core.rvalid) begin
            if (!r_seen) begin
                r_seen = 1; r_saved = {core.rresp, core.rdata};
                if (exp_r.size() == 0) chk("r_unexpected", exp_r.size(), 1);
                else begin
                    cur = exp_r[0];
                    if (cur.miss) chk("miss_latency", cyc - f_rhs, 1);
                    else chk("hit_err_latency", cyc - cur.hs, 1);
                end
            end else chk("r_stable", {core.rresp, core.rdata}, r_saved);
            if ($urandom_range(0, 3) != 0) begin
                core.rready = 1; r_hs_pend = 1;
                if (exp_r.size() > 0) begin
                    cur = exp_r.pop_front();
                    chk("rdata", core.rdata, cur.dat);
                    chk("rresp", core.rresp, cur.resp);
                end
            end
        end
    end

    task automatic write_seq();
        bit aw_hs = 0, w_hs = 0;
        core.awvalid = 1; core.awaddr = 0; core.wvalid = 1;
        core.wdata = 32'h1234_5678; core.wstrb = 4'hF; core.bready = 0;
        for (int i = 0; i < 20 && !(aw_hs && w_hs); i++) begin
            if (core.awvalid && core.awready) aw_hs = 1;
            if (core.wvalid && core.wready) w_hs = 1;
            @(negedge ACLK);
            if (aw_hs) core.awvalid = 0;
            if (w_hs) core.wvalid = 0;
        end
        chk("aw_w_accepted", {aw_hs, w_hs}, 2'b11);
        for (int i = 0; i < 5 && !core.bvalid; i++) @(negedge ACLK);
        repeat (5) begin
            chk("bvalid_held", core.bvalid, 1);
            chk("bresp_slverr", core.bresp, SLVERR);
            @(negedge ACLK);
        end
        core.bready = 1;
        @(negedge ACLK);
        core.bready = 0;
        chk("bvalid_cleared", core.bvalid, 0);
        @(negedge ACLK);
        chk("aw_w_ready_again", {core.awready, core.wready}, 2'b11);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] last, a;
        core.arvalid = 0; core.araddr = 0; core.awvalid = 0; core.awaddr = 0;
        core.wvalid = 0; core.wdata = 0; core.wstrb = 0; core.bready = 0;
        flash.awready = 0; flash.wready = 0; flash.bvalid = 0; flash.bresp = 0;
        repeat (3) @(negedge ACLK);
        chk("rst_arready", core.arready, 0);
        chk("rst_rvalid", core.rvalid, 0);
        chk("rst_rdata", core.rdata, 0);
        chk("rst_rresp", core.rresp, SLVERR);
        chk("rst_aw_w_ready", {core.awready, core.wready}, 2'b00);
        chk("rst_bvalid_bresp", {core.bvalid, core.bresp}, {1'b0, SLVERR});
        chk("rst_flash_ar", {flash.arvalid, flash.araddr}, 33'd0);
        chk("rst_flash_rready", flash.rready, 0);
        ARESETn = 1;
        @(negedge ACLK);

        // Reset while the flash read is outstanding
        f_delay_force = 40;
        do_read(32'h10);
        for (int i = 0; i < 50 && f_st != 1; i++) @(negedge ACLK);
        chk("reached_miss_r", f_st, 1);
        @(negedge ACLK);
        ARESETn = 0;
        #1;
        chk("mid_rst_core", {core.arready, core.rvalid, core.rdata, core.rresp}, {2'b00, 32'h0, SLVERR});
        chk("mid_rst_flash", {flash.arvalid, flash.araddr, flash.rready}, 34'd0);
        chk("mid_rst_bvalid", core.bvalid, 0);
        @(negedge ACLK);
        ARESETn = 1;
        exp_r.delete(); exp_f.delete(); m_vld = 0; f_pushed = f_done; f_delay_force = -1;
        @(negedge ACLK);
        do_read(32'h10);
        wait_idle();

        do_read(32'h100); do_read(32'h104); wait_idle();
        do_read(32'h100); do_read(32'h200); wait_idle();
        do_read(32'h7FFC); do_read(32'h8000); do_read(32'h8003); wait_idle();
        do_read(32'h40); do_read(32'h44); wait_idle();
        fork
            write_seq();
            begin
                repeat (2) @(negedge ACLK);
                do_read(32'h8);
            end
        join
        wait_idle();

        last = 32'h0;
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 5))
                0, 1:    a = last + 32'd4;
                2:       a = 32'h7FE0 + ($urandom_range(0, 15) << 2);
                3:       a = $urandom_range(0, 32'h9FFF);
                4:       a = last;
                default: a = $urandom_range(0, 63) << 2;
            endcase
            a[1:0] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) wait_idle();
            do_read(a);
            last = a & 32'hFFFF_FFFC;
        end
        wait_idle();
        repeat (5) @(negedge ACLK);
        chk("r_queue_drained", exp_r.size(), 0);
        chk("flash_queue_drained", exp_f.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
